// File: rtl/serial_add_pkg.sv
// ---------------------------------------------------------------------------
// serial_add_pkg
//   Shared definitions for the nibble-serial adder:
//     - state_e      : controller states (IDLE, ADD, DONE)
//     - NIB_W        : width of one arithmetic slice (4 bits)
//     - idx_width()  : width of the slice index, $clog2(nib) but never below 1
// ---------------------------------------------------------------------------
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NIB_W = 4;

    // A single-slice build still needs a 1-bit index register.
    function automatic int idx_width(input int nib);
        return (nib <= 1) ? 1 : $clog2(nib);
    endfunction

endpackage

// File: rtl/nibble_add_c.sv
// ---------------------------------------------------------------------------
// nibble_add_c
//   Combinational 4-bit adder slice with carry-in.
//   Ports:
//     a[3:0], b[3:0] : slice operands
//     cin            : carry into bit 0 of the slice
//     s[3:0]         : slice sum
//     cout           : carry out of bit 3 of the slice
// ---------------------------------------------------------------------------
module nibble_add_c
    import serial_add_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout
);

    logic [NIB_W:0] total;

    assign total     = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};
    assign {cout, s} = total;

endmodule

// File: rtl/serial_nibble_adder.sv
// ---------------------------------------------------------------------------
// serial_nibble_adder
//   Nibble-serial adder: one 4-bit slice per clock, carry registered between
//   slices. Latency from acceptance to out_valid is NIB = WIDTH/4 cycles;
//   one transaction per NIB+2 cycles at best.
//
//   Parameters:
//     WIDTH      : operand/result width, multiple of 4, >= 4
//   Ports:
//     clk        : clock, rising edge
//     rst_n      : synchronous active-low reset
//     in_valid   : operand pair present
//     in_ready   : block can accept operands (IDLE only)
//     in_a,in_b  : operands, registered on acceptance
//     in_sub     : subtract select (only when SERIAL_ADD_SUB_EN is defined)
//     out_valid  : result valid, held until out_ready
//     out_ready  : consumer takes result
//     out_sum    : result, modulo 2^WIDTH
//     out_cout   : carry out of the MSB (no-borrow when subtracting)
//     busy       : high whenever the controller is not IDLE
//
//   Optional feature macro: SERIAL_ADD_SUB_EN (adds in_sub and A-B mode).
//
//   Handshake: a transfer happens on a rising edge where valid && ready are
//   both high. in_ready and out_valid are registered; once out_valid rises,
//   it and out_sum/out_cout hold until the out_ready handshake completes.
//   in_valid outside IDLE is ignored, nothing is queued.
// ---------------------------------------------------------------------------
module serial_nibble_adder
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = idx_width(NIB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    state_e             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic               cout_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;
`ifdef SERIAL_ADD_SUB_EN
    logic               sub_q;
`endif

    // Slice datapath: the single adder is steered by idx_q.
    logic [NIB_W-1:0]   a_slice_d;
    logic [NIB_W-1:0]   b_slice_d;
    logic [NIB_W-1:0]   s_slice_d;
    logic               c_slice_d;
    logic [IDX_W-1:0]   idx_d;

    assign a_slice_d = a_q[idx_q*NIB_W +: NIB_W];
`ifdef SERIAL_ADD_SUB_EN
    // Two's-complement subtract: invert B slice-by-slice, seed carry with 1.
    assign b_slice_d = sub_q ? ~b_q[idx_q*NIB_W +: NIB_W] : b_q[idx_q*NIB_W +: NIB_W];
`else
    assign b_slice_d = b_q[idx_q*NIB_W +: NIB_W];
`endif
    assign idx_d = idx_q + 1'b1;

    nibble_add_c u_nibble_add (
        .a    (a_slice_d),
        .b    (b_slice_d),
        .cin  (carry_q),
        .s    (s_slice_d),
        .cout (c_slice_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= in_a;
                        b_q        <= in_b;
                        sum_q      <= '0;
                        idx_q      <= '0;
                        cout_q     <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
                        sub_q      <= in_sub;
                        carry_q    <= in_sub;
`else
                        carry_q    <= 1'b0;
`endif
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ADD;
                    end
                end
                ADD: begin
                    sum_q[idx_q*NIB_W +: NIB_W] <= s_slice_d;
                    carry_q <= c_slice_d;
                    idx_q   <= idx_d;
                    if (idx_q == LAST_IDX) begin
                        cout_q      <= c_slice_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign busy      = busy_q;

endmodule
